// File: rtl/morse_timing_receiver.sv
// morse_timing_receiver: straight-key Morse receiver that times presses and releases
// to classify dots/dashes and detect character and word gaps.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   tick       one-cycle sample strobe; all timing counts ticks
//   key_in     debounced key level (1 = pressed), synchronous to clk
//   morse_code symbols of the last character, first symbol in bit 0, 1 = dash
//   morse_len  number of valid symbols in morse_code
//   code_valid one-cycle pulse when morse_code/morse_len update
//   word_gap   one-cycle pulse at a detected word gap
//   error      one-cycle pulse when a character is discarded (overflow / stuck key)
//   busy       high whenever the receiver is not idle
//   tone_out   sidetone square wave while keyed (only with MORSE_RX_SIDETONE_EN)
// Build option: define MORSE_RX_SIDETONE_EN to build the sidetone toggle register.
module morse_timing_receiver #(
    parameter int UNIT_TICKS = 200,
    parameter int MIN_TICKS  = 10,
    parameter int MAX_LEN    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               key_in,
    output logic [MAX_LEN-1:0] morse_code,
    output logic [2:0]         morse_len,
    output logic               code_valid,
    output logic               word_gap,
    output logic               error,
    output logic               busy,
    output logic               tone_out
);
    localparam int CW = $clog2(8*UNIT_TICKS+1);
    localparam logic [CW-1:0] C_SAT  = CW'(8*UNIT_TICKS);
    localparam logic [CW-1:0] C_SAT1 = CW'(8*UNIT_TICKS-1);
    localparam logic [CW-1:0] C_MIN  = CW'(MIN_TICKS);
    localparam logic [CW-1:0] C_DASH = CW'(2*UNIT_TICKS);
    localparam logic [CW-1:0] C_CH   = CW'(2*UNIT_TICKS-1);
    localparam logic [CW-1:0] C_WD   = CW'(5*UNIT_TICKS-1);
    localparam logic [2:0]    C_MAXL = 3'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, WORD_WAIT} state_t;

    state_t             r_state, w_state;
    logic [CW-1:0]      r_cnt, w_cnt;
    logic [MAX_LEN-1:0] r_sr, w_sr;
    logic [2:0]         r_len, w_len;
    logic               r_flag, w_flag;
    logic               w_cv, w_err, w_wg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_len      <= '0;
            r_flag     <= 1'b0;
            morse_code <= '0;
            morse_len  <= '0;
            code_valid <= 1'b0;
            error      <= 1'b0;
            word_gap   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_sr       <= w_sr;
            r_len      <= w_len;
            r_flag     <= w_flag;
            code_valid <= w_cv;
            error      <= w_err;
            word_gap   <= w_wg;
            if (w_cv) begin
                morse_code <= r_sr;
                morse_len  <= r_len;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_sr    = r_sr;
        w_len   = r_len;
        w_flag  = r_flag;
        w_cv    = 1'b0;
        w_err   = 1'b0;
        w_wg    = 1'b0;
        if (tick) begin
            case (r_state)
                IDLE: if (key_in) begin
                    w_state = MARK;
                    w_cnt   = CW'(1);
                end
                MARK: if (key_in) begin
                    w_cnt  = (r_cnt == C_SAT) ? r_cnt : r_cnt + CW'(1);
                    // stuck key flagged the tick the counter reaches saturation
                    w_flag = r_flag | (r_cnt >= C_SAT1);
                end else begin
                    w_cnt   = '0;
                    w_state = SPACE;
                    if (r_cnt >= C_SAT) begin
                        w_flag = 1'b1;
                    end else if (r_cnt < C_MIN) begin
                        w_state = (r_len != 3'd0) ? SPACE : IDLE;
                    end else if (r_len == C_MAXL) begin
                        w_flag = 1'b1;
                    end else begin
                        w_sr  = r_sr | (MAX_LEN'(r_cnt >= C_DASH) << r_len);
                        w_len = r_len + 3'd1;
                    end
                end
                SPACE: if (key_in) begin
                    w_state = MARK;
                    w_cnt   = CW'(1);
                end else if (r_cnt == C_CH) begin
                    w_err   = r_flag;
                    w_cv    = !r_flag && (r_len != 3'd0);
                    w_sr    = '0;
                    w_len   = '0;
                    w_flag  = 1'b0;
                    w_cnt   = '0;
                    w_state = WORD_WAIT;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
                WORD_WAIT: if (key_in) begin
                    w_state = MARK;
                    w_cnt   = CW'(1);
                end else if (r_cnt == C_WD) begin
                    w_wg    = 1'b1;
                    w_cnt   = '0;
                    w_state = IDLE;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
                default: w_state = IDLE;
            endcase
        end
    end

`ifdef MORSE_RX_SIDETONE_EN
    logic r_tone;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_tone <= 1'b0;
        else
            r_tone <= (r_state == MARK && key_in) ? (r_tone ^ tick) : 1'b0;
    end
`endif

    always_comb begin
        busy = (r_state != IDLE);
`ifdef MORSE_RX_SIDETONE_EN
        tone_out = r_tone;
`else
        tone_out = 1'b0;
`endif
    end
endmodule

// File: tb/tb_morse_timing_receiver.sv
// tb_morse_timing_receiver: directed and random keying checked against a duration-level model.
module tb_morse_timing_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick;
    logic       key_in = 1'b0;
    logic [4:0] morse_code;
    logic [2:0] morse_len;
    logic       code_valid, word_gap, error, busy, tone_out;

    int errors = 0;
    int checks = 0;
    int ph = 0;
    int seg[$];
    int ev_q[$];
    int exp_q[$];
    int m_len, m_sr, m_flag, m_phase, m_code, m_mlen;

    morse_timing_receiver #(.UNIT_TICKS(10), .MIN_TICKS(2), .MAX_LEN(5)) dut (
        .clk(clk), .rst(rst), .tick(tick), .key_in(key_in),
        .morse_code(morse_code), .morse_len(morse_len), .code_valid(code_valid),
        .word_gap(word_gap), .error(error), .busy(busy), .tone_out(tone_out)
    );

    always #5 clk = ~clk;
    always @(negedge clk) ph <= (ph + 1) % 4;
    assign tick = (ph == 3);

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (code_valid) ev_q.push_back((1 << 8) | (int'(morse_code) << 3) | int'(morse_len));
        if (error) ev_q.push_back(2 << 8);
        if (word_gap) ev_q.push_back(3 << 8);
        if (code_valid || error) chk("cv_err_exclusive", int'(code_valid & error), 0);
`ifdef MORSE_RX_SIDETONE_EN
        if (!busy) chk("tone_idle", int'(tone_out), 0);
`else
        chk("tone_off", int'(tone_out), 0);
`endif
    end

    task automatic key_for(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) begin
            do @(posedge clk); while (!tick);
        end
        #1;
    endtask

    task automatic model_reset();
        m_len = 0; m_sr = 0; m_flag = 0; m_phase = 0; m_code = 0; m_mlen = 0;
    endtask

    // Press of d ticks: <2 glitch, >=80 stuck, >=20 dash, else dot.
    task automatic model_press(input int d);
        if (d >= 80) begin
            m_flag = 1; m_phase = 1;
        end else if (d < 2) begin
            m_phase = (m_len > 0) ? 1 : 0;
        end else begin
            if (m_len == 5) m_flag = 1;
            else begin
                if (d >= 20) m_sr = m_sr | (1 << m_len);
                m_len++;
            end
            m_phase = 1;
        end
    endtask

    // Release of r ticks: 20 ends a character, 50 more end a word.
    task automatic model_release(input int r);
        int rem = r;
        if (m_phase == 1 && rem >= 20) begin
            if (m_flag != 0) exp_q.push_back(2 << 8);
            else if (m_len > 0) begin
                exp_q.push_back((1 << 8) | (m_sr << 3) | m_len);
                m_code = m_sr; m_mlen = m_len;
            end
            m_sr = 0; m_len = 0; m_flag = 0; m_phase = 2;
            rem -= 20;
        end
        if (m_phase == 2 && rem >= 50) begin
            exp_q.push_back(3 << 8);
            m_phase = 0;
        end
    endtask

    task automatic run_scn(input string name);
        ev_q.delete();
        exp_q.delete();
        foreach (seg[i]) begin
            if (i % 2 == 0) model_press(seg[i]); else model_release(seg[i]);
            key_for(i % 2 == 0, seg[i]);
        end
        chk({name, "_events"}, ev_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i < ev_q.size()) chk({name, "_ev"}, ev_q[i], exp_q[i]);
        chk({name, "_code"}, int'(morse_code), m_code);
        chk({name, "_len"}, int'(morse_len), m_mlen);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", int'(morse_code), 0);
        chk("rst_len", int'(morse_len), 0);
        chk("rst_pulses", int'({code_valid, error, word_gap}), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        key_for(0, 5);

        seg = '{5, 10, 25, 80};
        run_scn("A");
        chk("A_model_code", m_code, 5'b00010);
        seg = '{5, 3, 1, 80};
        run_scn("E_glitch");
        seg = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 80};
        run_scn("overflow");
        seg = '{85, 25, 25, 80};
        run_scn("stuck_T");

        ev_q.delete();
        key_for(1, 5); key_for(0, 10); key_for(1, 25); key_for(0, 10); key_for(1, 10);
        chk("mark_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_code", int'(morse_code), 0);
        chk("rst_mid_len", int'(morse_len), 0);
        chk("rst_mid_pulses", int'({code_valid, error, word_gap}), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_tone", int'(tone_out), 0);
        key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        key_for(0, 80);
        chk("post_rst_quiet", ev_q.size(), 0);
        seg = '{25, 80};
        run_scn("post_rst_T");

        for (int r = 0; r < 5; r++) begin
            int nchar = $urandom_range(1, 4);
            seg.delete();
            for (int c = 0; c < nchar; c++) begin
                int nsym = $urandom_range(1, 6);
                for (int s = 0; s < nsym; s++) begin
                    int p = $urandom_range(0, 9);
                    seg.push_back(p == 0 ? 1 : (p < 5 ? $urandom_range(2, 19) : $urandom_range(20, 50)));
                    if (s < nsym - 1) seg.push_back($urandom_range(1, 19));
                    else seg.push_back(c == nchar - 1 ? 80 : $urandom_range(20, 90));
                end
            end
            run_scn("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
